sump_link_ctrl: RTL and testbench
=================================

// Module: sump_link_ctrl
// PURPOSE
//  Sequencer between the byte-wide UART link and the logic-analyzer core.
//  RX side: assembles SUMP commands from received bytes, drives the core's
//  40-bit command bus and a one-cycle exec pulse.
//  TX side: accepts 32-bit sample words from the core under a ready/strobe
//  handshake and serializes them into bytes for the UART transmitter.
//  Sits between uart_rx/uart_tx and the core top.
// PARAMETERS
//  TX_BYTES        4      bytes emitted per core word (1..4), LSB first
//  TIMEOUT_CYCLES  50000  idle cycles that abort a partial long command; 0 = never
// PORTS
//  clk_i          in   1   system clock
//  rst_i          in   1   synchronous reset, active high
//  rx_data_i      in   8   received byte
//  rx_stb_i       in   1   rx_data_i valid, one-cycle pulse per byte
//  cmd_o          out  40  {opcode[39:32], param[31:0]} to core cmd_i
//  exec_o         out  1   one-cycle pulse: cmd_o valid, to core exec_i
//  core_tx_i      in   32  sample word from core tx_o
//  core_tx_stb_i  in   1   core_tx_i valid, from core tx_stb_o
//  core_tx_rdy_o  out  1   word can be accepted, to core tx_rdy_i
//  tx_data_o      out  8   byte to UART transmitter
//  tx_stb_o       out  1   tx_data_o valid; held until tx_ack_i
//  tx_ack_i       in   1   transmitter accepted byte this cycle
// BEHAVIOUR
//  Reset: cmd_o=0, exec_o=0, core_tx_rdy_o=1, tx_data_o=0, tx_stb_o=0.
//   RX FSM -> IDLE, TX FSM -> IDLE, partial command/word discarded.
//  RX FSM (IDLE, PARAM):
//  - IDLE, rx_stb_i, rx_data_i[7]=0 (short cmd): cmd_o<={byte,32'h0};
//    exec_o=1 in next cycle. Stay IDLE.
//  - IDLE, rx_stb_i, rx_data_i[7]=1 (long cmd): latch opcode, pcnt<=0 -> PARAM.
//  - PARAM, rx_stb_i: byte k (k=0..3) -> param[8k+7:8k]. After k=3,
//    cmd_o<={opcode,param}, exec_o=1 next cycle -> IDLE.
//  - Latency: final byte sampled at edge N -> exec_o high in cycle N+1 only.
//  - cmd_o changes only together with an exec_o pulse; held otherwise.
//  - Timeout: in PARAM a counter clears on every rx_stb_i and increments
//    otherwise; reaching TIMEOUT_CYCLES -> IDLE, no exec, params dropped.
//    Counter width $clog2(TIMEOUT_CYCLES+1); unused when TIMEOUT_CYCLES=0.
//  - Back-to-back bytes (rx_stb_i every cycle) fully supported; a new
//    command may start in the cycle exec_o is high.
//  TX FSM (IDLE, SEND):
//  - core_tx_rdy_o=1 exactly when TX FSM is IDLE.
//  - IDLE, core_tx_stb_i=1: capture core_tx_i, idx<=0, -> SEND; rdy low
//    from next cycle. core_tx_stb_i while rdy=0 is ignored (core contract).
//  - SEND: tx_stb_o=1, tx_data_o=word[8*idx+7:8*idx]. On tx_ack_i, idx++;
//    after ack of byte TX_BYTES-1 -> IDLE, tx_stb_o=0, rdy=1 next cycle.
//  - tx_data_o stable while tx_stb_o=1 and no ack. Ack while tx_stb_o=0 ignored.
//  - Throughput: at most one byte per cycle; min TX_BYTES+1 cycles per word.
//  RX and TX FSMs independent; simultaneous activity has no interaction.
//  rst_i mid-command or mid-word: aborted immediately, no exec, no stray byte.
// TESTING
//  1 rx 0x00 -> exec_o 1 cycle later, cmd_o=40'h00_00000000; single pulse.
//  2 rx 0xC0,0x78,0x56,0x34,0x12 (back-to-back) -> one exec_o, cmd_o=
//    40'hC0_12345678; no exec after first four bytes.
//  3 TIMEOUT_CYCLES=16: rx 0x81,0xAA then 16 idle cycles, then 0x02 ->
//    no exec for 0x81; exec with cmd_o=40'h02_00000000.
//  4 core word 32'hDEADBEEF, tx_ack_i every 3rd cycle -> bytes EF,BE,AD,DE,
//    data stable while waiting; core_tx_rdy_o low until after 4th ack.
//  5 TX_BYTES=2, word 32'h0000A55A, ack always 1 -> 5A,A5 in consecutive
//    cycles, rdy high the following cycle; second word accepted immediately.
//  6 rst_i after 2 param bytes and during byte 1 of a word -> outputs at
//    reset values next cycle; following full command executes correctly.

Source files
------------

// File: rtl/sump_link_ctrl.sv
// SUMP link sequencer: assembles 1- or 5-byte commands from the UART receiver
// for the analyzer core, and serializes 32-bit core sample words into UART bytes.
module sump_link_ctrl #(
  parameter int TX_BYTES       = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_stb_i,
  output logic [39:0] cmd_o,
  output logic        exec_o,
  input  logic [31:0] core_tx_i,
  input  logic        core_tx_stb_i,
  output logic        core_tx_rdy_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_stb_o,
  input  logic        tx_ack_i
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] T_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0]    IDX_LAST = 2'(TX_BYTES - 1);

  typedef enum logic { RX_IDLE = 1'b0, RX_PARAM = 1'b1 } rx_state_t;
  typedef enum logic { TX_IDLE = 1'b0, TX_SEND  = 1'b1 } tx_state_t;

  // Full FSM state kept in one struct per side so checkers can bind to it.
  typedef struct packed {
    rx_state_t     state;
    logic [1:0]    pcnt;
    logic [TW-1:0] tcnt;
    logic [7:0]    opcode;
    logic [23:0]   param;
  } rx_reg_t;

  typedef struct packed {
    tx_state_t   state;
    logic [1:0]  idx;
    logic [23:0] sh;
  } tx_reg_t;

  rx_reg_t rx_q;
  tx_reg_t tx_q;

  // RX: the fourth parameter byte goes straight into cmd_o, so only three are buffered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_q   <= '0;
      cmd_o  <= '0;
      exec_o <= 1'b0;
    end else begin
      exec_o <= 1'b0;
      case (rx_q.state)
        RX_IDLE: begin
          if (rx_stb_i) begin
            if (rx_data_i[7]) begin
              rx_q.opcode <= rx_data_i;
              rx_q.pcnt   <= 2'd0;
              rx_q.tcnt   <= '0;
              rx_q.state  <= RX_PARAM;
            end else begin
              cmd_o  <= {rx_data_i, 32'h0};
              exec_o <= 1'b1;
            end
          end
        end
        RX_PARAM: begin
          if (rx_stb_i) begin
            rx_q.tcnt <= '0;
            case (rx_q.pcnt)
              2'd0: rx_q.param[7:0]   <= rx_data_i;
              2'd1: rx_q.param[15:8]  <= rx_data_i;
              2'd2: rx_q.param[23:16] <= rx_data_i;
              default: begin
                cmd_o      <= {rx_q.opcode, rx_data_i, rx_q.param};
                exec_o     <= 1'b1;
                rx_q.state <= RX_IDLE;
              end
            endcase
            rx_q.pcnt <= rx_q.pcnt + 2'd1;
          end else if (TIMEOUT_CYCLES != 0) begin
            if (rx_q.tcnt == T_LAST) begin
              rx_q.state <= RX_IDLE;
            end else begin
              rx_q.tcnt <= rx_q.tcnt + TW'(1);
            end
          end
        end
        default: rx_q.state <= RX_IDLE;
      endcase
    end
  end

  // Handshakes: the core may strobe a word only while core_tx_rdy_o is high
  // (accepted on that edge); a byte is consumed on every edge where
  // tx_stb_o and tx_ack_i are both high, and tx_data_o holds until then.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q          <= '0;
      core_tx_rdy_o <= 1'b1;
      tx_data_o     <= 8'h0;
      tx_stb_o      <= 1'b0;
    end else begin
      case (tx_q.state)
        TX_IDLE: begin
          if (core_tx_stb_i) begin
            tx_q.sh       <= core_tx_i[31:8];
            tx_q.idx      <= 2'd0;
            tx_q.state    <= TX_SEND;
            tx_data_o     <= core_tx_i[7:0];
            tx_stb_o      <= 1'b1;
            core_tx_rdy_o <= 1'b0;
          end
        end
        TX_SEND: begin
          if (tx_ack_i) begin
            if (tx_q.idx == IDX_LAST) begin
              tx_q.state    <= TX_IDLE;
              tx_stb_o      <= 1'b0;
              core_tx_rdy_o <= 1'b1;
            end else begin
              tx_q.idx  <= tx_q.idx + 2'd1;
              tx_data_o <= tx_q.sh[7:0];
              tx_q.sh   <= {8'h0, tx_q.sh[23:8]};
            end
          end
        end
        default: tx_q.state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sump_link_ctrl.sv
// Bench for sump_link_ctrl: table-driven RX command vectors plus hand-written
// TX serialization and mid-transaction reset sequences.
module tb_sump_link_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_stb;
  logic [39:0] cmd;
  logic        exec;
  logic [31:0] core_tx;
  logic        core_tx_stb;
  logic        core_tx_rdy;
  logic [7:0]  tx_data;
  logic        tx_stb;
  logic        tx_ack;

  logic [7:0]  rx_data_b;
  logic        rx_stb_b;
  logic [39:0] cmd_b;
  logic        exec_b;
  logic [31:0] core_tx_b;
  logic        core_tx_stb_b;
  logic        core_tx_rdy_b;
  logic [7:0]  tx_data_b;
  logic        tx_stb_b;
  logic        tx_ack_b;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        stb;
    logic [7:0]  data;
    logic        exp_exec;
    logic [39:0] exp_cmd;
    string       name;
  } rx_vec_t;

  rx_vec_t     vecs[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;

  always #5 clk = ~clk;

  sump_link_ctrl #(.TX_BYTES(4), .TIMEOUT_CYCLES(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_stb_i(rx_stb),
    .cmd_o(cmd), .exec_o(exec),
    .core_tx_i(core_tx), .core_tx_stb_i(core_tx_stb), .core_tx_rdy_o(core_tx_rdy),
    .tx_data_o(tx_data), .tx_stb_o(tx_stb), .tx_ack_i(tx_ack)
  );

  sump_link_ctrl #(.TX_BYTES(2), .TIMEOUT_CYCLES(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data_b), .rx_stb_i(rx_stb_b),
    .cmd_o(cmd_b), .exec_o(exec_b),
    .core_tx_i(core_tx_b), .core_tx_stb_i(core_tx_stb_b), .core_tx_rdy_o(core_tx_rdy_b),
    .tx_data_o(tx_data_b), .tx_stb_o(tx_stb_b), .tx_ack_i(tx_ack_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_byte(input string name, input logic [7:0] b, input logic e,
                          input logic [39:0] c);
    vecs.push_back('{stb: 1'b1, data: b, exp_exec: e, exp_cmd: c, name: name});
  endtask

  task automatic add_idle(input string name, input int n, input logic [39:0] c);
    for (int i = 0; i < n; i++)
      vecs.push_back('{stb: 1'b0, data: 8'h00, exp_exec: 1'b0, exp_cmd: c, name: name});
  endtask

  task automatic chk_tx(input string name, input logic s, input logic [7:0] d, input logic r);
    chk({name, " tx_stb"}, tx_stb, s);
    if (s) chk({name, " tx_data"}, tx_data, d);
    chk({name, " rdy"}, core_tx_rdy, r);
  endtask

  task automatic send_rx(input string name, input logic [7:0] b, input logic e,
                         input logic [39:0] c);
    rx_stb  = 1'b1;
    rx_data = b;
    tick();
    rx_stb  = 1'b0;
    chk({name, " exec"}, exec, e);
    if (e) chk({name, " cmd"}, cmd, c);
  endtask

  initial begin
    rst = 1'b1;
    rx_data = 8'h0; rx_stb = 1'b0; core_tx = 32'h0; core_tx_stb = 1'b0; tx_ack = 1'b0;
    rx_data_b = 8'h0; rx_stb_b = 1'b0; core_tx_b = 32'h0; core_tx_stb_b = 1'b0; tx_ack_b = 1'b0;
    tick();
    tick();
    chk("reset cmd", cmd, 40'h0);
    chk("reset exec", exec, 1'b0);
    chk("reset rdy", core_tx_rdy, 1'b1);
    chk("reset tx_data", tx_data, 8'h0);
    chk("reset tx_stb", tx_stb, 1'b0);
    chk("reset rdy_b", core_tx_rdy_b, 1'b1);
    chk("reset tx_stb_b", tx_stb_b, 1'b0);
    rst = 1'b0;

    // RX vectors: each row is the input at one edge and the outputs just after it.
    add_byte("short00", 8'h00, 1'b1, 40'h00_00000000);
    add_idle("short00 single", 2, 40'h00_00000000);
    add_byte("short11", 8'h11, 1'b1, 40'h11_00000000);
    add_idle("short11 hold", 1, 40'h11_00000000);
    add_byte("long op", 8'hC0, 1'b0, 40'h11_00000000);
    add_byte("long p0", 8'h78, 1'b0, 40'h11_00000000);
    add_byte("long p1", 8'h56, 1'b0, 40'h11_00000000);
    add_byte("long p2", 8'h34, 1'b0, 40'h11_00000000);
    add_byte("long p3", 8'h12, 1'b1, 40'hC0_12345678);
    add_byte("b2b short", 8'h05, 1'b1, 40'h05_00000000);
    add_idle("b2b idle", 1, 40'h05_00000000);
    add_byte("to op", 8'h81, 1'b0, 40'h05_00000000);
    add_byte("to p0", 8'hAA, 1'b0, 40'h05_00000000);
    add_idle("to wait", 16, 40'h05_00000000);
    add_byte("to after", 8'h02, 1'b1, 40'h02_00000000);
    add_idle("to idle", 1, 40'h02_00000000);
    add_byte("edge op", 8'h81, 1'b0, 40'h02_00000000);
    add_idle("edge wait", 15, 40'h02_00000000);
    add_byte("edge p0", 8'h01, 1'b0, 40'h02_00000000);
    add_byte("edge p1", 8'h02, 1'b0, 40'h02_00000000);
    add_byte("edge p2", 8'h03, 1'b0, 40'h02_00000000);
    add_byte("edge p3", 8'h04, 1'b1, 40'h81_04030201);
    add_byte("hi op", 8'h9F, 1'b0, 40'h81_04030201);
    add_byte("hi p0", 8'hFF, 1'b0, 40'h81_04030201);
    add_byte("hi p1", 8'h80, 1'b0, 40'h81_04030201);
    add_byte("hi p2", 8'h7F, 1'b0, 40'h81_04030201);
    add_byte("hi p3", 8'h01, 1'b1, 40'h9F_017F80FF);
    add_idle("hi idle", 1, 40'h9F_017F80FF);

    for (int i = 0; i < vecs.size(); i++) begin
      rx_stb  = vecs[i].stb;
      rx_data = vecs[i].data;
      tick();
      chk({vecs[i].name, " exec"}, exec, vecs[i].exp_exec);
      chk({vecs[i].name, " cmd"}, cmd, vecs[i].exp_cmd);
    end
    rx_stb = 1'b0;

    // TX: 0xDEADBEEF with an ack every third cycle; a second strobe while busy is ignored.
    exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    core_tx     = 32'hDEADBEEF;
    core_tx_stb = 1'b1;
    tick();
    core_tx = 32'h11111111;
    for (int b = 0; b < 4; b++) begin
      exp_b = exp_q.pop_front();
      chk_tx($sformatf("word byte%0d", b), 1'b1, exp_b, 1'b0);
      for (int w = 0; w < 2; w++) begin
        tick();
        chk_tx($sformatf("word wait%0d.%0d", b, w), 1'b1, exp_b, 1'b0);
      end
      if (b == 3) core_tx_stb = 1'b0;
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
    end
    chk_tx("word done", 1'b0, 8'h00, 1'b1);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk_tx("stray ack", 1'b0, 8'h00, 1'b1);

    // TX_BYTES=2 with ack held high: one byte per cycle, next word right away.
    tx_ack_b      = 1'b1;
    core_tx_b     = 32'h0000A55A;
    core_tx_stb_b = 1'b1;
    tick();
    core_tx_stb_b = 1'b0;
    chk("b w1 stb0", tx_stb_b, 1'b1);
    chk("b w1 data0", tx_data_b, 8'h5A);
    chk("b w1 rdy0", core_tx_rdy_b, 1'b0);
    tick();
    chk("b w1 stb1", tx_stb_b, 1'b1);
    chk("b w1 data1", tx_data_b, 8'hA5);
    tick();
    chk("b w1 done stb", tx_stb_b, 1'b0);
    chk("b w1 done rdy", core_tx_rdy_b, 1'b1);
    core_tx_b     = 32'h0000C33C;
    core_tx_stb_b = 1'b1;
    tick();
    core_tx_stb_b = 1'b0;
    chk("b w2 data0", tx_data_b, 8'h3C);
    chk("b w2 rdy0", core_tx_rdy_b, 1'b0);
    tick();
    chk("b w2 data1", tx_data_b, 8'hC3);
    tick();
    chk("b w2 done stb", tx_stb_b, 1'b0);
    chk("b w2 done rdy", core_tx_rdy_b, 1'b1);
    tx_ack_b = 1'b0;

    // Reset mid-command and mid-word, then a clean long command.
    rx_stb = 1'b1; rx_data = 8'h80;
    core_tx = 32'h44332211; core_tx_stb = 1'b1;
    tick();
    core_tx_stb = 1'b0;
    rx_data = 8'h01; tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    rx_data = 8'h02;
    tick();
    rx_stb = 1'b0;
    chk_tx("pre-reset", 1'b1, 8'h22, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst cmd", cmd, 40'h0);
    chk("mid rst exec", exec, 1'b0);
    chk("mid rst rdy", core_tx_rdy, 1'b1);
    chk("mid rst tx_data", tx_data, 8'h0);
    chk("mid rst tx_stb", tx_stb, 1'b0);
    send_rx("post op", 8'hC0, 1'b0, 40'h0);
    send_rx("post p0", 8'h78, 1'b0, 40'h0);
    send_rx("post p1", 8'h56, 1'b0, 40'h0);
    send_rx("post p2", 8'h34, 1'b0, 40'h0);
    send_rx("post p3", 8'h12, 1'b1, 40'hC0_12345678);
    tick();
    chk("post idle exec", exec, 1'b0);
    chk("post idle tx_stb", tx_stb, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
